riscv_wb_port_arbiter: RTL and testbench
========================================

Name: riscv_wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order writeback stage and a long-latency unit (LU, e.g. multi-cycle mul/div) with a valid/ready handshake. The pipeline always has priority. LU results wait in a small FIFO, or bypass it when the port is free. A starvation counter requests a writeback bubble from the hazard unit, and a pending-rd scoreboard lets the hazard unit stall dependent readers.

Parameters:
DEPTH, 2, LU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive lost-arbitration cycles before o_stall_req asserts (1..15)
DATA_W, `XLEN, write-data width

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_wb_en  in  1  writeback stage write request (o_ctrl_reg_wr_enW)
i_wb_addr  in  5  writeback rd address
i_wb_data  in  DATA_W  writeback rd data
i_lu_valid  in  1  LU result valid
o_lu_ready  out  1  arbiter accepts LU result this cycle
i_lu_addr  in  5  LU rd address
i_lu_data  in  DATA_W  LU rd data
o_rf_wr_en  out  1  regfile write enable
o_rf_wr_addr  out  5  regfile write address
o_rf_wr_data  out  DATA_W  regfile write data
o_stall_req  out  1  request a W-stage bubble (i_wb_en low) from the hazard unit
o_pending_mask  out  32  bit r set = a live FIFO entry targets xr
o_fifo_cnt  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, i_rstn=0): FIFO empty, all valid/live bits 0, starve counter 0. Outputs: o_lu_ready=1, o_rf_wr_en=0, o_rf_wr_addr=0, o_rf_wr_data=0, o_stall_req=0, o_pending_mask=0, o_fifo_cnt=0. Reset mid-operation drops every queued LU result.
- Port outputs are combinational from the current inputs and state. The regfile writes on the same edge. Zero added latency for the pipeline.
- pipe_req = i_wb_en & (i_wb_addr!=0). A write to x0 never uses the port.
- Grant priority, evaluated each cycle:
  1. pipe_req: port = wb inputs.
  2. Else if the FIFO head is valid: port = head, head pops. If the head's live bit is 0, it pops with o_rf_wr_en=0.
  3. Else if FIFO empty and i_lu_valid and i_lu_addr!=0: bypass, port = LU inputs. Handshake completes and nothing is enqueued.
  4. Else o_rf_wr_en=0.
- o_lu_ready = (o_fifo_cnt<DEPTH) | pop_this_cycle.
- Enqueue on i_lu_valid & o_lu_ready when not bypassed.
- An LU result with i_lu_addr==0 is accepted and discarded (never enqueued).
- Enqueue and pop in the same cycle are allowed. Count is unchanged, pointers wrap mod DEPTH.
- WAW kill: when pipe_req hits an address held by a live FIFO entry, that entry's live bit clears on the edge (the pipeline write is younger).
  - An LU result enqueued in the same cycle with the same address stays live (LU is younger).
- o_pending_mask is the OR of the one-hot addresses of live, valid entries. It is registered and reflects the FIFO state after the last edge.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO head is valid & live and pipe_req wins.
  - Clears on any head pop and whenever the FIFO is empty.
- o_stall_req = (counter==STARVE_LIMIT). It stays high until the head pops.
- If i_wb_en stays high while o_stall_req is high, the pipeline still wins. There is no deadlock, only a delay.
- Full FIFO with pipe_req active: o_lu_ready=0 and the LU must hold its data stable until accepted.

Test Plan:
- Idle port, FIFO empty, LU valid addr=5 data=0xA5A5A5A5 -> same-cycle o_rf_wr_en=1 addr=5 data=0xA5A5A5A5, o_lu_ready=1, o_fifo_cnt stays 0.
- i_wb_en=1 addr=3 each cycle while LU pushes addr=7 then addr=8 -> port carries only x3; o_fifo_cnt=2, o_lu_ready=0, o_pending_mask=0x180; after 4 lost cycles o_stall_req=1; drop i_wb_en -> x7 written, then x8, o_stall_req=0, mask=0.
- LU enqueues addr=9, next cycle the pipeline writes x9=0x11 -> live bit cleared, mask bit 9 clears; when the pipeline idles the entry pops with o_rf_wr_en=0 and x9 keeps 0x11.
- Full FIFO, pipeline idle, LU valid addr=4 -> head pops, new entry enqueues the same cycle, o_fifo_cnt stays 2, pointers wrap correctly over 3+ rounds.
- i_wb_en=1 addr=0 with FIFO head x6 -> head granted (x6 written), nothing written to x0; LU addr=0 accepted with no write.
- FIFO holding 2 entries with o_stall_req=1, assert i_rstn=0 mid-cycle -> all outputs immediately 0 except o_lu_ready=1; after release no stale write occurs.

Source files
------------

// File: rtl/riscv_wb_port_arbiter.sv
// rtl/riscv_wb_port_arbiter.sv - regfile write-port arbiter between writeback and a long-latency unit
`ifndef XLEN
`define XLEN 32
`endif

module riscv_wb_port_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = `XLEN
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_wb_en,
   input  logic [4:0]              i_wb_addr,
   input  logic [DATA_W-1:0]       i_wb_data,
   input  logic                    i_lu_valid,
   output logic                    o_lu_ready,
   input  logic [4:0]              i_lu_addr,
   input  logic [DATA_W-1:0]       i_lu_data,
   output logic                    o_rf_wr_en,
   output logic [4:0]              o_rf_wr_addr,
   output logic [DATA_W-1:0]       o_rf_wr_data,
   output logic                    o_stall_req,
   output logic [31:0]             o_pending_mask,
   output logic [$clog2(DEPTH):0]  o_fifo_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

   logic [4:0]        addr_q [DEPTH];
   logic [4:0]        addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  live_q, live_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        starve_q, starve_d;
   logic [31:0]       pending_q, pending_d;

   logic pipe_req;
   logic head_valid;
   logic head_live;
   logic pop;
   logic bypass;
   logic lu_ready;
   logic enq;

   always_comb begin
      pipe_req   = i_wb_en && (i_wb_addr != 5'd0);
      head_valid = valid_q[rd_ptr_q];
      head_live  = live_q[rd_ptr_q];
      pop        = !pipe_req && head_valid;
      bypass     = !pipe_req && !head_valid && i_lu_valid && (i_lu_addr != 5'd0);
      lu_ready   = (cnt_q < DEPTH_C) || pop;
      // x0 results complete the handshake but never occupy a slot
      enq        = i_lu_valid && lu_ready && !bypass && (i_lu_addr != 5'd0);
   end

   always_comb begin
      o_rf_wr_en   = 1'b0;
      o_rf_wr_addr = 5'd0;
      o_rf_wr_data = '0;
      o_lu_ready   = lu_ready;
      if (pipe_req) begin
         o_rf_wr_en   = 1'b1;
         o_rf_wr_addr = i_wb_addr;
         o_rf_wr_data = i_wb_data;
      end else if (pop) begin
         o_rf_wr_en = head_live;
         if (head_live) begin
            o_rf_wr_addr = addr_q[rd_ptr_q];
            o_rf_wr_data = data_q[rd_ptr_q];
         end
      end else if (bypass) begin
         o_rf_wr_en   = 1'b1;
         o_rf_wr_addr = i_lu_addr;
         o_rf_wr_data = i_lu_data;
      end
      // Port is forced quiet while reset is held, whatever the inputs do
      if (!i_rstn) begin
         o_rf_wr_en   = 1'b0;
         o_rf_wr_addr = 5'd0;
         o_rf_wr_data = '0;
         o_lu_ready   = 1'b1;
      end
   end

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      live_d   = live_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         live_d[rd_ptr_q]  = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end

      // Younger pipeline write makes queued results for the same rd obsolete
      if (pipe_req) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == i_wb_addr)) live_d[i] = 1'b0;
         end
      end

      if (enq) begin
         addr_d[wr_ptr_q]  = i_lu_addr;
         data_d[wr_ptr_q]  = i_lu_data;
         valid_d[wr_ptr_q] = 1'b1;
         live_d[wr_ptr_q]  = 1'b1;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end

      case ({enq, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      if (pop || !head_valid) begin
         starve_d = 4'd0;
      end else if (pipe_req && head_live && (starve_q != LIMIT_C)) begin
         starve_d = starve_q + 4'd1;
      end

      pending_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_d[i] && live_d[i]) pending_d = pending_d | (32'd1 << addr_d[i]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 5'd0;
            data_q[i] <= '0;
         end
         valid_q   <= '0;
         live_q    <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         starve_q  <= 4'd0;
         pending_q <= '0;
      end else begin
         addr_q    <= addr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         live_q    <= live_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         pending_q <= pending_d;
      end
   end

   assign o_stall_req    = (starve_q == LIMIT_C);
   assign o_pending_mask = pending_q;
   assign o_fifo_cnt     = cnt_q;

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// tb/tb_riscv_wb_port_arbiter.sv - randomized model-based bench for riscv_wb_port_arbiter
module tb_riscv_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        stall_req;
   logic [31:0] pending_mask;
   logic [1:0]  fifo_cnt;

   riscv_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_lu_valid(lu_valid), .o_lu_ready(lu_ready), .i_lu_addr(lu_addr), .i_lu_data(lu_data),
      .o_rf_wr_en(rf_wr_en), .o_rf_wr_addr(rf_wr_addr), .o_rf_wr_data(rf_wr_data),
      .o_stall_req(stall_req), .o_pending_mask(pending_mask), .o_fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          live;
   } ent_t;

   ent_t q[$];
   int   starve;
   bit   lu_acc;
   int   n_checks;
   int   n_pass;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic set_in(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld);
      wb_en = we; wb_addr = wa; wb_data = wd;
      lu_valid = lv; lu_addr = la; lu_data = ld;
   endtask

   // Called just after a rising edge; checks at the falling edge, then advances the model.
   task automatic run_cycle();
      bit          pipe, pop, byp, rdy, e_en;
      logic [4:0]  e_a;
      logic [31:0] e_d, e_mask;
      int          nst;
      @(negedge clk);
      pipe = wb_en && (wb_addr != 0);
      pop = 0; byp = 0; e_en = 0; e_a = 0; e_d = 0;
      if (pipe) begin
         e_en = 1; e_a = wb_addr; e_d = wb_data;
      end else if (q.size() > 0) begin
         pop = 1; e_en = q[0].live; e_a = q[0].addr; e_d = q[0].data;
      end else if (lu_valid && lu_addr != 0) begin
         byp = 1; e_en = 1; e_a = lu_addr; e_d = lu_data;
      end
      rdy = (q.size() < DEPTH) || pop;
      e_mask = 0;
      foreach (q[i]) if (q[i].live) e_mask[q[i].addr] = 1'b1;

      check_eq("rf_wr_en", rf_wr_en, e_en);
      if (e_en) begin
         check_eq("rf_wr_addr", rf_wr_addr, e_a);
         check_eq("rf_wr_data", rf_wr_data, e_d);
      end
      check_eq("lu_ready", lu_ready, rdy);
      check_eq("stall_req", stall_req, starve == LIMIT);
      check_eq("pending_mask", pending_mask, e_mask);
      check_eq("fifo_cnt", fifo_cnt, q.size());

      lu_acc = lu_valid && rdy;
      if (q.size() == 0 || pop) nst = 0;
      else if (pipe && q[0].live && starve < LIMIT) nst = starve + 1;
      else nst = starve;
      if (pop) void'(q.pop_front());
      if (pipe) foreach (q[i]) if (q[i].addr == wb_addr) q[i].live = 0;
      if (lu_acc && !byp && lu_addr != 0) q.push_back('{lu_addr, lu_data, 1'b1});
      starve = nst;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_wr_en"}, rf_wr_en, 0);
      check_eq({tag, "_wr_addr"}, rf_wr_addr, 0);
      check_eq({tag, "_wr_data"}, rf_wr_data, 0);
      check_eq({tag, "_ready"}, lu_ready, 1);
      check_eq({tag, "_stall"}, stall_req, 0);
      check_eq({tag, "_mask"}, pending_mask, 0);
      check_eq({tag, "_cnt"}, fifo_cnt, 0);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; starve = 0; lu_acc = 0;
      rstn = 1'b0;
      set_in(1, 5'd3, 32'h1234, 1, 5'd5, 32'h55);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      set_in(0, 0, 0, 0, 0, 0);
      rstn = 1'b1;

      // idle port: LU result bypasses the FIFO
      set_in(0, 0, 0, 1, 5'd5, 32'hA5A5A5A5);
      run_cycle();
      check_eq("bypass_cnt", fifo_cnt, 0);

      // pipeline hogs the port while x7, x8 queue up, then starvation
      set_in(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
      run_cycle();
      set_in(1, 5'd3, 32'h34, 1, 5'd8, 32'h88);
      run_cycle();
      check_eq("s2_cnt", fifo_cnt, 2);
      check_eq("s2_mask", pending_mask, 32'h180);
      set_in(1, 5'd3, 32'h35, 0, 0, 0);
      repeat (3) run_cycle();
      check_eq("s2_stall", stall_req, 1);
      set_in(1, 5'd3, 32'h36, 0, 0, 0);
      run_cycle();
      check_eq("s2_stall_held", stall_req, 1);
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) run_cycle();
      check_eq("s2_drained_cnt", fifo_cnt, 0);
      check_eq("s2_drained_mask", pending_mask, 0);
      check_eq("s2_drained_stall", stall_req, 0);

      // WAW kill of a queued x9
      set_in(1, 5'd3, 32'h1, 1, 5'd9, 32'h99);
      run_cycle();
      check_eq("waw_mask_set", pending_mask, 32'h200);
      set_in(1, 5'd9, 32'h11, 0, 0, 0);
      run_cycle();
      check_eq("waw_mask_clr", pending_mask, 0);
      set_in(0, 0, 0, 0, 0, 0);
      run_cycle();

      // full FIFO with idle pipeline: pop and push every cycle, pointers wrap
      set_in(1, 5'd2, 32'h2, 1, 5'd4, 32'h40);
      run_cycle();
      set_in(1, 5'd2, 32'h2, 1, 5'd4, 32'h41);
      run_cycle();
      for (int i = 0; i < 7; i++) begin
         set_in(0, 0, 0, 1, 5'd4, 32'h100 + i);
         run_cycle();
         check_eq("wrap_cnt", fifo_cnt, 2);
      end
      set_in(0, 0, 0, 0, 0, 0);
      repeat (3) run_cycle();

      // x0 writeback does not block the head; x0 LU result is swallowed
      set_in(1, 5'd3, 32'h3, 1, 5'd6, 32'h66);
      run_cycle();
      set_in(1, 5'd0, 32'hDEAD, 0, 0, 0);
      run_cycle();
      set_in(0, 0, 0, 1, 5'd0, 32'hBEEF);
      run_cycle();
      check_eq("x0_lu_cnt", fifo_cnt, 0);

      // reset mid-operation with two queued entries and stall asserted
      set_in(1, 5'd3, 32'h3, 1, 5'd10, 32'hA0);
      run_cycle();
      set_in(1, 5'd3, 32'h3, 1, 5'd11, 32'hB0);
      run_cycle();
      set_in(1, 5'd3, 32'h3, 0, 0, 0);
      repeat (4) run_cycle();
      check_eq("pre_reset_stall", stall_req, 1);
      #2 rstn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      q.delete(); starve = 0;
      set_in(0, 0, 0, 0, 0, 0);
      rstn = 1'b1;
      repeat (2) run_cycle();

      // randomized traffic, LU holds data until accepted
      lu_acc = 1;
      set_in(0, 0, 0, 0, 0, 0);
      for (int blk = 0; blk < 40; blk++) begin
         int busy_pct;
         busy_pct = (blk % 3 == 0) ? 95 : $urandom_range(10, 70);
         for (int c = 0; c < 50; c++) begin
            wb_en   = ($urandom_range(0, 99) < busy_pct);
            wb_addr = 5'($urandom_range(0, 9));
            wb_data = $urandom;
            if (!lu_valid || lu_acc) begin
               lu_valid = ($urandom_range(0, 99) < 55);
               lu_addr  = 5'($urandom_range(0, 9));
               lu_data  = $urandom;
            end
            run_cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
